// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter register and instruction-fetch sequencer. Holds the
//   architectural PC, fetches the instruction at PC over a req/gnt/rvalid
//   memory handshake, buffers it and presents it to decode with a
//   valid/ready handshake. When decode accepts, the PC loads the next-PC
//   adder result and the next fetch starts.
//
//   Optional build macro: IFETCH_ALIGN_CHECK_EN
//     defined   : a misaligned next_pc at the accept edge is loaded as is,
//                 raises the sticky fetch_fault and parks the unit in
//                 S_FAULT until rst.
//     undefined : next_pc[1:0] is forced to zero on load and fetch_fault
//                 is tied low.
//
//   Ports
//     clk, rst     : clock, synchronous active-high reset
//     next_pc      : next PC from the next-PC adder
//     pc           : current PC (to the next-PC adder and decode)
//     imem_req     : fetch request, held stable until imem_gnt
//     imem_addr    : fetch address (equals pc)
//     imem_gnt     : memory accepted the request
//     imem_rvalid  : read data valid
//     imem_rdata   : read data
//     instr_out    : buffered instruction to decode
//     instr_valid  : instr_out and pc are valid for decode
//     instr_ready  : decode accepts the instruction this cycle
//     instr_count  : number of instructions accepted by decode (wraps)
//     fetch_fault  : sticky misalignment fault
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_count,
    output logic        fetch_fault
);

`ifdef IFETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] cnt_q;
    logic        req_q;
    logic        vld_q;

    logic [31:0] pc_d;
    logic [31:0] cnt_d;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic        fault_q;
    logic        misaligned;

    assign misaligned = (next_pc[1:0] != 2'b00);
    // A misaligned target is kept verbatim so the faulting PC is visible.
    assign pc_d       = misaligned ? next_pc : (next_pc & 32'hFFFF_FFFC);
`else
    assign pc_d       = next_pc & 32'hFFFF_FFFC;
`endif

    assign cnt_d = cnt_q + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                end
                // A same-cycle rvalid is not looked at here: only gnt counts.
                S_REQ: begin
                    if (imem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        vld_q   <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                // next_pc is sampled only on this accept edge.
                S_HOLD: begin
                    if (instr_ready) begin
                        vld_q <= 1'b0;
                        cnt_q <= cnt_d;
                        pc_q  <= pc_d;
`ifdef IFETCH_ALIGN_CHECK_EN
                        if (misaligned) begin
                            fault_q <= 1'b1;
                            state_q <= S_FAULT;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
`else
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
`endif
                    end
                end
`ifdef IFETCH_ALIGN_CHECK_EN
                S_FAULT: begin
                    req_q <= 1'b0;
                    vld_q <= 1'b0;
                end
`endif
                default: begin
                    req_q   <= 1'b0;
                    vld_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign instr_out   = instr_q;
    assign instr_valid = vld_q;
    assign instr_count = cnt_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer.
- Holds the architectural PC and feeds it to the next-PC adder, which computes PC+4 or the branch target.
- Loads that adder's result when decode accepts the current instruction.
- Fetches each instruction from instruction memory over a req/gnt/rvalid handshake and presents it to decode with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- next_pc  input  32  next PC from the next-PC adder (PC+4 or PC+4+imm*4).
- pc  output  32  current PC; drives the next-PC adder and decode.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; equals pc.
- imem_gnt  input  1  memory accepted the request.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read data.
- instr_out  output  32  buffered instruction to decode.
- instr_valid  output  1  instr_out and pc are valid for decode.
- instr_ready  input  1  decode accepts the instruction this cycle.
- instr_count  output  32  count of instructions accepted by decode.
- fetch_fault  output  1  sticky misalignment fault (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=S_IDLE, pc=RESET_PC, instr_out=0, instr_count=0, fetch_fault=0.
  - imem_req=0 and instr_valid=0 while in S_IDLE.
  - Reset mid-operation (any state) aborts the fetch; the instruction buffer is discarded.
  - imem shares rst, so it issues no response after reset.
- States and transitions:
  - S_IDLE: imem_req=0; next cycle -> S_REQ unconditionally.
  - S_REQ: imem_req=1, imem_addr=pc. imem_req and imem_addr stay stable until imem_gnt. On imem_gnt=1 -> S_WAIT.
  - S_WAIT: imem_req=0. On imem_rvalid=1: instr_out<=imem_rdata, -> S_HOLD.
  - S_HOLD: instr_valid=1, instr_out and pc stable. On instr_ready=1:
    - pc<={next_pc[31:2],2'b00}, instr_count<=instr_count+1 (wraps 32'hFFFF_FFFF -> 0).
    - -> S_REQ.
- imem_gnt outside S_REQ and imem_rvalid outside S_WAIT are ignored.
- imem_gnt and imem_rvalid in the same cycle while in S_REQ: only the gnt is taken; rvalid is ignored.
- next_pc is sampled only on the S_HOLD handshake edge; changes at any other time have no effect.
- pc changes only on reset or on the handshake edge.
- Latency:
  - gnt at cycle t, rvalid at cycle t+k (k>=1) -> instr_valid at t+k+1.
  - Handshake at cycle h -> imem_req=1 at h+1.
  - Minimum period is 4 cycles per instruction with gnt and rvalid each arriving one cycle after they become acceptable.
- instr_ready while instr_valid=0 has no effect.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Defined:
  - On the S_HOLD handshake, if next_pc[1:0]!=0: pc<=next_pc unmodified, fetch_fault<=1, -> S_FAULT.
  - S_FAULT: imem_req=0, instr_valid=0; held until rst.
  - instr_count still increments on the faulting handshake.
- Not defined: next_pc[1:0] is forced to 0 on load; fetch_fault is tied to 0; no S_FAULT state exists.

Test Plan:
- Release rst, gnt 1 cycle after req, rvalid 1 cycle after gnt, rdata=32'h2002_0005, instr_ready=1, next_pc=32'h4 -> imem_addr=0, instr_valid 3 cycles after first req, then pc=32'h4, instr_count=1.
- Hold imem_gnt=0 for 5 cycles -> imem_req=1 and imem_addr=RESET_PC stable throughout; no state change.
- Hold instr_ready=0 for 4 cycles in S_HOLD while toggling next_pc -> instr_out and pc unchanged; on ready, pc equals next_pc at that edge (e.g. 32'h0000_0040).
- Branch: pc=32'h10, next_pc=32'h24 at handshake -> next imem_addr=32'h24.
- Assert rst during S_WAIT with spurious rvalid after release -> pc=RESET_PC, instr_valid=0, instr_count=0, spurious rvalid ignored.
- With IFETCH_ALIGN_CHECK_EN: next_pc=32'h22 at handshake -> fetch_fault=1, imem_req=0 until rst. Without the macro: pc=32'h20, fetch continues.
